// File: rtl/lock_pkg.sv
// Shared types and width helpers for the digit lock controller.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    localparam int STATE_W = 2;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n inclusive.
    function automatic int ctr_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // One down-counter serves both timed states, so size it for the longer one.
    function automatic int timer_w(input int open_c, input int lock_c);
        return ctr_w(max(open_c, lock_c));
    endfunction

endpackage

// File: rtl/digit_shift_buffer.sv
// Serial digit entry buffer: newest digit lands in the low DW bits.
module digit_shift_buffer
    import lock_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int DW     = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       shift_en,
    input  logic [DW-1:0]              din,
    input  logic                       clear,
    output logic [DIGITS*DW-1:0]       digits,
    output logic [ctr_w(DIGITS)-1:0]   cnt,
    output logic                       full
);

    localparam int CW = ctr_w(DIGITS);

    logic [DIGITS*DW-1:0] din_ext;

    assign din_ext = (DIGITS*DW)'(din);
    assign full    = (cnt == CW'(DIGITS));

    // Clear has priority; a full buffer ignores further digits.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            digits <= '0;
            cnt    <= '0;
        end else if (clear) begin
            digits <= '0;
            cnt    <= '0;
        end else if (shift_en && !full) begin
            digits <= (digits << DW) | din_ext;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_lock_fsm.sv
// N-digit lock controller: set/compare password, failed-attempt lockout, timed unlock.
module digit_lock_fsm
    import lock_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int DW          = 4,
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          m,
    input  logic [DW-1:0]                 din,
    input  logic                          din_vld,
    input  logic                          confirm,
    output logic [DIGITS*DW-1:0]          disp,
    output logic [ctr_w(DIGITS)-1:0]      cnt,
    output logic                          res,
    output logic                          err,
    output logic                          set_done,
    output logic                          locked,
    output logic [ctr_w(MAX_TRIES)-1:0]   tries
);

    localparam int TW  = timer_w(OPEN_CYCLES, LOCK_CYCLES);
    localparam int TRW = ctr_w(MAX_TRIES);

    lock_state_t           state;
    logic [DIGITS*DW-1:0]  password;
    logic [TW-1:0]         timer;
    logic                  m_q;
    logic                  full;
    logic                  in_idle;
    logic                  mode_flip;
    logic                  full_confirm;
    logic                  shift_en;
    logic                  clear;
    logic [TRW-1:0]        tries_inc;

    assign in_idle      = (state == IDLE);
    // A mode change wipes the buffer, so a confirm in that cycle counts as short.
    assign mode_flip    = in_idle && (m_q != m);
    assign full_confirm = in_idle && confirm && full && !mode_flip;
    // Confirm wins over a simultaneous digit.
    assign shift_en     = in_idle && din_vld && !confirm && !mode_flip;
    // Keep the buffer only when heading into CHECK; it is dropped once CHECK finishes.
    assign clear        = (in_idle && (mode_flip || (confirm && !(full_confirm && m))))
                        || (state == CHECK);
    assign tries_inc    = tries + 1'b1;

    digit_shift_buffer #(
        .DIGITS (DIGITS),
        .DW     (DW)
    ) u_entry (
        .clk      (clk),
        .clr      (clr),
        .shift_en (shift_en),
        .din      (din),
        .clear    (clear),
        .digits   (disp),
        .cnt      (cnt),
        .full     (full)
    );

    // Lock controller: state, password, attempt counter, shared timer and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            password <= '0;
            timer    <= '0;
            m_q      <= 1'b0;
            res      <= 1'b0;
            err      <= 1'b0;
            set_done <= 1'b0;
            locked   <= 1'b0;
            tries    <= '0;
        end else begin
            m_q      <= m;
            err      <= 1'b0;
            set_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (confirm) begin
                        if (!full_confirm) begin
                            err <= 1'b1;
                        end else if (!m) begin
                            password <= disp;
                            set_done <= 1'b1;
                            tries    <= '0;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (disp == password) begin
                        tries <= '0;
                        timer <= TW'(OPEN_CYCLES);
                        res   <= 1'b1;
                        state <= OPEN;
                    end else begin
                        err   <= 1'b1;
                        tries <= tries_inc;
                        if (tries_inc == TRW'(MAX_TRIES)) begin
                            timer  <= TW'(LOCK_CYCLES);
                            locked <= 1'b1;
                            state  <= LOCKOUT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                OPEN: begin
                    if (timer == TW'(1)) begin
                        res   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == TW'(1)) begin
                        locked <= 1'b0;
                        tries  <= '0;
                        state  <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_lock_fsm.sv
// Bench for digit_lock_fsm: directed scenarios plus random traffic, all against a queue-based model.
module tb_digit_lock_fsm;

    localparam int D     = 6;
    localparam int W     = 4;
    localparam int MAXT  = 3;
    localparam int OPENC = 8;
    localparam int LOCKC = 16;

    logic             clk = 1'b0;
    logic             clr;
    logic             m;
    logic [W-1:0]     din;
    logic             din_vld;
    logic             confirm;
    logic [D*W-1:0]   disp;
    logic [2:0]       cnt;
    logic             res;
    logic             err;
    logic             set_done;
    logic             locked;
    logic [1:0]       tries;

    always #5 clk = ~clk;

    digit_lock_fsm #(
        .DIGITS      (D),
        .DW          (W),
        .MAX_TRIES   (MAXT),
        .OPEN_CYCLES (OPENC),
        .LOCK_CYCLES (LOCKC)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .m        (m),
        .din      (din),
        .din_vld  (din_vld),
        .confirm  (confirm),
        .disp     (disp),
        .cnt      (cnt),
        .res      (res),
        .err      (err),
        .set_done (set_done),
        .locked   (locked),
        .tries    (tries)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: digits held in a queue, timed states as remaining-cycle counts.
    int     q[$];
    longint pw;
    int     mt;
    int     open_left;
    int     lock_left;
    bit     pending;
    logic   prev_m;
    bit     e_err;
    bit     e_set;

    function automatic longint qval();
        longint v = 0;
        foreach (q[i]) v = (v << W) | longint'(q[i]);
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        pw = 0; mt = 0; open_left = 0; lock_left = 0;
        pending = 0; prev_m = 1'b0; e_err = 0; e_set = 0;
    endtask

    task automatic model_step(input logic mm, input logic vld, input logic [W-1:0] d, input logic cf);
        bit flip;
        e_err = 0;
        e_set = 0;
        if (pending) begin
            pending = 0;
            if (qval() == pw) begin
                mt = 0;
                open_left = OPENC;
            end else begin
                e_err = 1;
                mt++;
                if (mt == MAXT) lock_left = LOCKC;
            end
            q.delete();
        end else if (open_left > 0) begin
            open_left--;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) mt = 0;
        end else begin
            flip = (mm != prev_m);
            if (flip) q.delete();
            if (cf) begin
                if (flip || q.size() < D) begin
                    e_err = 1;
                    q.delete();
                end else if (!mm) begin
                    pw = qval();
                    e_set = 1;
                    mt = 0;
                    q.delete();
                end else begin
                    pending = 1;
                end
            end else if (vld && !flip && q.size() < D) begin
                q.push_back(int'(d));
            end
        end
        prev_m = mm;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("disp",     32'(disp),     32'(qval()));
        check("cnt",      32'(cnt),      32'(q.size()));
        check("res",      32'(res),      32'(open_left > 0));
        check("err",      32'(err),      32'(e_err));
        check("set_done", 32'(set_done), 32'(e_set));
        check("locked",   32'(locked),   32'(lock_left > 0));
        check("tries",    32'(tries),    32'(mt));
    endtask

    task automatic cycle(input logic mm, input logic vld, input logic [W-1:0] d, input logic cf);
        m = mm; din_vld = vld; din = d; confirm = cf;
        @(posedge clk);
        model_step(mm, vld, d, cf);
        #1;
        check_all();
    endtask

    task automatic press(input logic mm, input int d);
        cycle(mm, 1'b1, W'(d), 1'b0);
    endtask

    task automatic conf(input logic mm);
        cycle(mm, 1'b0, '0, 1'b1);
    endtask

    task automatic idle(input logic mm);
        cycle(mm, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int   hi;
        logic rm;

        clr = 1'b1; m = 1'b0; din = '0; din_vld = 1'b0; confirm = 1'b0;
        model_reset();
        #12;
        check("rst_disp",   32'(disp),   32'h0);
        check("rst_cnt",    32'(cnt),    32'h0);
        check("rst_res",    32'(res),    32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_tries",  32'(tries),  32'h0);
        check("rst_err",    32'(err),    32'h0);
        clr = 1'b0;

        // Set password 123456.
        for (int i = 1; i <= 6; i++) press(1'b0, i);
        check("full_disp", 32'(disp), 32'h123456);
        conf(1'b0);
        check("set_pulse", 32'(set_done), 32'h1);
        check("set_cnt",   32'(cnt),      32'h0);
        idle(1'b0);
        check("set_once",  32'(set_done), 32'h0);

        // Correct entry opens for exactly OPENC cycles.
        idle(1'b1);
        for (int i = 1; i <= 6; i++) press(1'b1, i);
        conf(1'b1);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            idle(1'b1);
            if (i == 0) check("res_lat", 32'(res), 32'h1);
            if (res) hi++;
        end
        check("res_len", 32'(hi), 32'(OPENC));

        // Three wrong entries lead to lockout.
        for (int t = 1; t <= 2; t++) begin
            for (int i = 6; i >= 1; i--) press(1'b1, i);
            conf(1'b1);
            idle(1'b1);
            check("fail_err",   32'(err),   32'h1);
            check("fail_tries", 32'(tries), 32'(t));
        end
        for (int i = 6; i >= 1; i--) press(1'b1, i);
        conf(1'b1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, i < 16, 4'h7, i == 5);
            if (i == 0) check("lock_tries", 32'(tries), 32'h3);
            if (locked) begin
                hi++;
                check("lock_cnt", 32'(cnt), 32'h0);
            end
        end
        check("lock_len",   32'(hi),    32'(LOCKC));
        check("lock_clear", 32'(tries), 32'h0);

        // Short entry, overflow, and digit dropped by a concurrent confirm.
        for (int i = 1; i <= 3; i++) press(1'b1, i);
        conf(1'b1);
        check("short_err",   32'(err),   32'h1);
        check("short_tries", 32'(tries), 32'h0);
        for (int i = 1; i <= 7; i++) press(1'b1, i);
        check("ovf_disp", 32'(disp), 32'h123456);
        check("ovf_cnt",  32'(cnt),  32'h6);
        idle(1'b0);
        idle(1'b1);
        for (int i = 1; i <= 5; i++) press(1'b1, i);
        cycle(1'b1, 1'b1, 4'h6, 1'b1);
        check("drop_err", 32'(err), 32'h1);
        check("drop_cnt", 32'(cnt), 32'h0);

        // Mode flip clears the buffer.
        for (int i = 1; i <= 3; i++) press(1'b1, i);
        idle(1'b0);
        check("flip_cnt",  32'(cnt),  32'h0);
        check("flip_disp", 32'(disp), 32'h0);

        // Async clear in the middle of OPEN, then the all-zero password.
        idle(1'b1);
        for (int i = 1; i <= 6; i++) press(1'b1, i);
        conf(1'b1);
        idle(1'b1);
        idle(1'b1);
        #3;
        clr = 1'b1;
        #1;
        check("aclr_res", 32'(res), 32'h0);
        check("aclr_cnt", 32'(cnt), 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        clr = 1'b0;
        idle(1'b1);
        for (int i = 0; i < 6; i++) press(1'b1, 0);
        conf(1'b1);
        idle(1'b1);
        check("zero_pw_res", 32'(res), 32'h1);
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Random traffic with binary digits so matches occur now and then.
        rm = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) rm = ~rm;
            cycle(rm, 1'($urandom_range(0, 1)), W'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
